// File: rtl/color_matrix.sv
// ============================================================================
// Module   : color_matrix
// Brief    : Streaming 3x3 colour-matrix converter (bypass/gray/matrix/invert),
//            3-cycle latency, double-buffered coefficients committed at frame
//            start. Optional macro COLOR_MATRIX_OFFSET_EN adds per-channel offsets.
// Revision : 1.0
// ============================================================================
`default_nettype none

module color_matrix #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 10,
    parameter int FRAC   = 8,
    parameter int POS_W  = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [POS_W-1:0]  POSX,
    input  logic [POS_W-1:0]  POSY,
    input  logic              READY,
    output logic              RDEN,
    input  logic [DATA_W-1:0] IN_R,
    input  logic [DATA_W-1:0] IN_G,
    input  logic [DATA_W-1:0] IN_B,
    input  logic [1:0]        MODE,
    input  logic              CFG_WE,
    input  logic [3:0]        CFG_ADDR,
    input  logic [COEF_W-1:0] CFG_WDATA,
    output logic              CFG_PENDING,
    output logic              WREN,
    output logic [DATA_W-1:0] OUT_R,
    output logic [DATA_W-1:0] OUT_G,
    output logic [DATA_W-1:0] OUT_B
);

    localparam int PW = DATA_W + COEF_W + 1;
    localparam int SW = PW + 2;

    localparam logic [1:0] c_MODE_BYP  = 2'd0;
    localparam logic [1:0] c_MODE_GRAY = 2'd1;
    localparam logic [1:0] c_MODE_MAT  = 2'd2;
    localparam logic [1:0] c_MODE_INV  = 2'd3;

    localparam logic signed [COEF_W-1:0] c_ONE  = COEF_W'(1 << FRAC);
    localparam logic signed [COEF_W-1:0] c_GR   = COEF_W'(77 << (FRAC - 8));
    localparam logic signed [COEF_W-1:0] c_GG   = COEF_W'(150 << (FRAC - 8));
    localparam logic signed [COEF_W-1:0] c_GB   = COEF_W'(29 << (FRAC - 8));
    localparam logic signed [SW-1:0]     c_RND  = SW'(1 << (FRAC - 1));
    localparam logic signed [SW-1:0]     c_PMAX = SW'((1 << DATA_W) - 1);

    function automatic logic signed [COEF_W-1:0] f_ident(input int k);
        return (k == 0 || k == 4 || k == 8) ? c_ONE : '0;
    endfunction

    function automatic logic [DATA_W-1:0] f_clamp(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] sh;
        sh = s >>> FRAC;
        if (sh < 0)
            return '0;
        else if (sh > c_PMAX)
            return '1;
        else
            return sh[DATA_W-1:0];
    endfunction

    logic signed [COEF_W-1:0] r_sh_coef  [9];
    logic signed [COEF_W-1:0] r_act_coef [9];
    logic                     r_pending;
    logic [1:0]               r_mode;

    logic        w_fs;
    logic        w_swap;
    logic        w_commit;
    logic [1:0]  w_mode_eff;

    assign RDEN        = READY;
    assign CFG_PENDING = r_pending;
    assign w_fs        = READY && (POSX == '0) && (POSY == '0);
    assign w_swap      = w_fs && r_pending;
    assign w_commit    = CFG_WE && (CFG_ADDR == 4'd15);
    assign w_mode_eff  = w_fs ? MODE : r_mode;

    // Shadow/active register set; the swap reads shadow before any same-cycle write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 9; k++) begin
                r_sh_coef[k]  <= f_ident(k);
                r_act_coef[k] <= f_ident(k);
            end
            r_pending <= 1'b0;
            r_mode    <= c_MODE_BYP;
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (CFG_WE && CFG_ADDR == 4'(k))
                    r_sh_coef[k] <= CFG_WDATA;
                if (w_swap)
                    r_act_coef[k] <= r_sh_coef[k];
            end
            if (w_fs)
                r_mode <= MODE;
            if (w_commit)
                r_pending <= 1'b1;
            else if (w_swap)
                r_pending <= 1'b0;
        end
    end

`ifdef COLOR_MATRIX_OFFSET_EN
    logic signed [COEF_W-1:0] r_sh_off  [3];
    logic signed [COEF_W-1:0] r_act_off [3];
    logic signed [COEF_W-1:0] w_off     [3];
    logic signed [COEF_W-1:0] r_off1    [3];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < 3; c++) begin
                r_sh_off[c]  <= '0;
                r_act_off[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (CFG_WE && CFG_ADDR == 4'(9 + c))
                    r_sh_off[c] <= CFG_WDATA;
                if (w_swap)
                    r_act_off[c] <= r_sh_off[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            w_off[c] = '0;
            if (w_mode_eff == c_MODE_MAT)
                w_off[c] = w_swap ? r_sh_off[c] : r_act_off[c];
        end
    end
`endif

    logic signed [COEF_W-1:0] w_coef [9];
    logic signed [PW-1:0]     w_px   [3];
    logic signed [PW-1:0]     w_prod [9];

    // Invert is done on the inputs so it shares the identity datapath.
    always_comb begin
        w_px[0] = PW'({1'b0, (w_mode_eff == c_MODE_INV) ? ~IN_R : IN_R});
        w_px[1] = PW'({1'b0, (w_mode_eff == c_MODE_INV) ? ~IN_G : IN_G});
        w_px[2] = PW'({1'b0, (w_mode_eff == c_MODE_INV) ? ~IN_B : IN_B});
        for (int k = 0; k < 9; k++) begin
            w_coef[k] = f_ident(k);
            case (w_mode_eff)
                c_MODE_GRAY: w_coef[k] = (k % 3 == 0) ? c_GR : ((k % 3 == 1) ? c_GG : c_GB);
                c_MODE_MAT:  w_coef[k] = w_swap ? r_sh_coef[k] : r_act_coef[k];
                default:     w_coef[k] = f_ident(k);
            endcase
            w_prod[k] = w_px[k % 3] * PW'(w_coef[k]);
        end
    end

    logic signed [PW-1:0]     r_prod [9];
    logic signed [SW-1:0]     r_sum  [3];
    logic [DATA_W-1:0]        r_out  [3];
    logic [2:0]               r_vld;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 9; k++)
                r_prod[k] <= '0;
            for (int c = 0; c < 3; c++) begin
                r_sum[c] <= '0;
                r_out[c] <= '0;
            end
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[1:0], READY};
            for (int k = 0; k < 9; k++)
                r_prod[k] <= w_prod[k];
            for (int c = 0; c < 3; c++) begin
`ifdef COLOR_MATRIX_OFFSET_EN
                r_sum[c] <= SW'(r_prod[3*c]) + SW'(r_prod[3*c+1]) + SW'(r_prod[3*c+2])
                          + (SW'(r_off1[c]) <<< FRAC) + c_RND;
`else
                r_sum[c] <= SW'(r_prod[3*c]) + SW'(r_prod[3*c+1]) + SW'(r_prod[3*c+2])
                          + c_RND;
`endif
                if (r_vld[1])
                    r_out[c] <= f_clamp(r_sum[c]);
            end
        end
    end

`ifdef COLOR_MATRIX_OFFSET_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < 3; c++)
                r_off1[c] <= '0;
        end else begin
            for (int c = 0; c < 3; c++)
                r_off1[c] <= w_off[c];
        end
    end
`endif

    assign WREN  = r_vld[2];
    assign OUT_R = r_out[0];
    assign OUT_G = r_out[1];
    assign OUT_B = r_out[2];

endmodule

`default_nettype wire

// File: tb/tb_color_matrix.sv
// ============================================================================
// Module   : tb_color_matrix
// Brief    : Directed-vector scoreboard bench for color_matrix.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_color_matrix;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [11:0] POSX = '0, POSY = '0;
    logic        READY = 1'b0;
    logic        RDEN;
    logic [7:0]  IN_R = '0, IN_G = '0, IN_B = '0;
    logic [1:0]  MODE = '0;
    logic        CFG_WE = 1'b0;
    logic [3:0]  CFG_ADDR = '0;
    logic [9:0]  CFG_WDATA = '0;
    logic        CFG_PENDING;
    logic        WREN;
    logic [7:0]  OUT_R, OUT_G, OUT_B;

    color_matrix dut (
        .CLK(CLK), .RST(RST), .POSX(POSX), .POSY(POSY), .READY(READY), .RDEN(RDEN),
        .IN_R(IN_R), .IN_G(IN_G), .IN_B(IN_B), .MODE(MODE),
        .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_WDATA(CFG_WDATA),
        .CFG_PENDING(CFG_PENDING), .WREN(WREN),
        .OUT_R(OUT_R), .OUT_G(OUT_G), .OUT_B(OUT_B)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [23:0] rgb;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge CLK) cyc++;

    // Monitor: every output pixel is matched against the oldest expectation.
    always @(negedge CLK) begin
        if (!RST && WREN) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pixel: got %h at cycle %0d, expected no output",
                         {OUT_R, OUT_G, OUT_B}, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({OUT_R, OUT_G, OUT_B} !== e.rgb || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL pixel: got %h at cycle %0d, expected %h at cycle %0d",
                             {OUT_R, OUT_G, OUT_B}, cyc, e.rgb, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Called one time unit after a rising edge; pixel is captured at the next edge.
    task automatic send(input int x, input int y, input int r, input int g, input int b,
                        input logic [23:0] e);
        exp_t t;
        t.rgb = e;
        t.cyc = cyc + 3;
        q.push_back(t);
        POSX  = 12'(x);
        POSY  = 12'(y);
        IN_R  = 8'(r);
        IN_G  = 8'(g);
        IN_B  = 8'(b);
        READY = 1'b1;
        @(posedge CLK);
        #1;
        READY = 1'b0;
    endtask

    task automatic cfg(input int addr, input int d);
        CFG_WE    = 1'b1;
        CFG_ADDR  = 4'(addr);
        CFG_WDATA = 10'(d);
        @(posedge CLK);
        #1;
        CFG_WE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("reset_wren", 32'(WREN), 32'd0);
        check("reset_out", 32'({OUT_R, OUT_G, OUT_B}), 32'd0);
        check("reset_pending", 32'(CFG_PENDING), 32'd0);
        RST = 1'b0;
        idle(1);

        // Bypass, with no output before latency 3
        MODE = 2'd0;
        send(0, 0, 10, 200, 255, {8'd10, 8'd200, 8'd255});
        @(negedge CLK);
        check("early_out_1", 32'({WREN, OUT_R, OUT_G, OUT_B}), 32'd0);
        @(negedge CLK);
        check("early_out_2", 32'({WREN, OUT_R, OUT_G, OUT_B}), 32'd0);
        @(posedge CLK);
        #1;
        idle(3);

        // Gray latched at FS; a later MODE change in the frame has no effect
        MODE = 2'd1;
        send(0, 0, 100, 50, 200, {8'd82, 8'd82, 8'd82});
        send(1, 0, 255, 255, 255, {8'd255, 8'd255, 8'd255});
        MODE = 2'd0;
        send(2, 0, 100, 50, 200, {8'd82, 8'd82, 8'd82});
        idle(4);

        // Program clamp matrix (511 is the largest positive 10-bit coefficient)
        cfg(0, -256); cfg(1, 0); cfg(2, 0);
        cfg(3, 511);  cfg(4, 0); cfg(5, 0);
        cfg(15, 0);
        check("pending_after_commit", 32'(CFG_PENDING), 32'd1);
        MODE = 2'd2;
        send(3, 0, 100, 50, 200, {8'd82, 8'd82, 8'd82});
        check("pending_mid_frame", 32'(CFG_PENDING), 32'd1);
        send(0, 0, 200, 7, 9, {8'd0, 8'd255, 8'd9});
        check("pending_cleared_fs", 32'(CFG_PENDING), 32'd0);
        idle(4);

        // Invert
        MODE = 2'd3;
        send(0, 0, 0, 128, 255, {8'd255, 8'd127, 8'd0});
        idle(4);

        // Commit coincident with FS: old set kept for this frame
        cfg(0, 256); cfg(3, 0); cfg(4, 256);
        MODE      = 2'd2;
        CFG_WE    = 1'b1;
        CFG_ADDR  = 4'd15;
        CFG_WDATA = '0;
        send(0, 0, 200, 7, 9, {8'd0, 8'd255, 8'd9});
        CFG_WE = 1'b0;
        check("pending_coincident", 32'(CFG_PENDING), 32'd1);
        send(1, 0, 200, 7, 9, {8'd0, 8'd255, 8'd9});
        idle(3);
        send(0, 0, 200, 7, 9, {8'd200, 8'd7, 8'd9});
        check("pending_next_fs", 32'(CFG_PENDING), 32'd0);
        idle(4);

        // Reset with pixels in flight
        MODE = 2'd1;
        send(0, 0, 100, 50, 200, {8'd82, 8'd82, 8'd82});
        send(1, 0, 100, 50, 200, {8'd82, 8'd82, 8'd82});
        send(2, 0, 100, 50, 200, {8'd82, 8'd82, 8'd82});
        cfg(15, 0);
        RST = 1'b1;
        #1;
        check("async_rst_wren", 32'(WREN), 32'd0);
        check("async_rst_out", 32'({OUT_R, OUT_G, OUT_B}), 32'd0);
        check("async_rst_pending", 32'(CFG_PENDING), 32'd0);
        q.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(4);

        // Active set back to identity, then shadow back to identity
        MODE = 2'd2;
        send(0, 0, 200, 7, 9, {8'd200, 8'd7, 8'd9});
        cfg(15, 0);
        check("pending_post_reset", 32'(CFG_PENDING), 32'd1);
        send(0, 0, 200, 7, 9, {8'd200, 8'd7, 8'd9});
        check("pending_post_reset_fs", 32'(CFG_PENDING), 32'd0);

        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(posedge CLK);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pixels outstanding, expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
